// File: rtl/sram_axi_bridge_mc.sv
// sram_axi_bridge_mc: NUM_CH SRAM-like channels onto one AXI3 master.
// Round-robin grant, MAX_RD reads in flight, one write; AXI ID = channel.
// Ports: aclk/aresetn (sync, active-low); ch_* per-channel SRAM-like
//   request/response buses (flattened, channel i at slice i);
//   ar*/r*/aw*/w*/b* AXI3 master channels.
// Option: define SRAM_AXI_BRIDGE_RAW_CHECK_EN to block a read only when it
//   hits the pending write's word; otherwise any pending write blocks reads.
module sram_axi_bridge_mc #(
  parameter int NUM_CH = 2,
  parameter int MAX_RD = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [NUM_CH-1:0]     ch_wr,
  input  logic [2*NUM_CH-1:0]   ch_size,
  input  logic [4*NUM_CH-1:0]   ch_wstrb,
  input  logic [32*NUM_CH-1:0]  ch_addr,
  input  logic [32*NUM_CH-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]     ch_addr_ok,
  output logic [NUM_CH-1:0]     ch_data_ok,
  output logic [32*NUM_CH-1:0]  ch_rdata,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAITB
  } wst_t;

  wst_t          r_wst;
  logic [PW-1:0] r_ptr;
  logic [3:0]    r_rd_cnt [NUM_CH];
  logic [3:0]    r_rd_total;

  logic          r_arvalid;
  logic [3:0]    r_arid;
  logic [31:0]   r_araddr;
  logic [2:0]    r_arsize;

  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_bready;
  logic [3:0]    r_wch;
  logic [31:0]   r_waddr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [2:0]    r_awsize;

  logic              w_busy;
  logic              w_ar_free;
  logic              w_rd_room;
  logic [NUM_CH-1:0] w_elig;
  logic              w_gnt_vld;
  logic [PW-1:0]     w_gnt;
  logic [PW:0]       w_idx;
  logic [PW-1:0]     w_nxt_ptr;
  logic              w_rd_gnt;
  logic              w_wr_gnt;
  logic [31:0]       w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [3:0]        w_sel_wstrb;
  logic [1:0]        w_sel_size;
  logic [NUM_CH-1:0] w_rret;
  logic [NUM_CH-1:0] w_bret;
  logic              w_aw_done;
  logic              w_w_done;
  logic              w_unused_ok;

  assign w_unused_ok = ^{rresp, rlast, bresp};

  assign w_busy    = (r_wst != S_IDLE);
  // AR slot reusable when empty or draining this cycle
  assign w_ar_free = !r_arvalid || arready;
  assign w_rd_room = (r_rd_total < 4'(MAX_RD));

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_wr[i]) begin
        w_elig[i] = ch_req[i] && !w_busy && (r_rd_cnt[i] == 4'd0);
      end else begin
        w_elig[i] = ch_req[i] && w_ar_free && w_rd_room
`ifdef SRAM_AXI_BRIDGE_RAW_CHECK_EN
          && !(w_busy && (r_wch == 4'(i)))
          && !(w_busy && (ch_addr[32*i+2 +: 30] == r_waddr[31:2]));
`else
          && !w_busy;
`endif
      end
    end
  end

  // round-robin scan starting at r_ptr
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NUM_CH)) begin
        w_idx = w_idx - (PW+1)'(NUM_CH);
      end
      if (!w_gnt_vld && w_elig[w_idx[PW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx[PW-1:0];
      end
    end
  end

  assign w_nxt_ptr = (w_gnt == PW'(NUM_CH-1)) ? '0 : w_gnt + PW'(1);

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    w_sel_size  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gnt == PW'(i)) begin
        w_sel_addr  = ch_addr[32*i +: 32];
        w_sel_wdata = ch_wdata[32*i +: 32];
        w_sel_wstrb = ch_wstrb[4*i +: 4];
        w_sel_size  = ch_size[2*i +: 2];
      end
    end
  end

  assign w_rd_gnt = w_gnt_vld && !ch_wr[w_gnt];
  assign w_wr_gnt = w_gnt_vld && ch_wr[w_gnt];

  always_comb begin
    ch_addr_ok = '0;
    w_rret     = '0;
    w_bret     = '0;
    ch_rdata   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_addr_ok[i] = w_gnt_vld && (w_gnt == PW'(i));
      w_rret[i]     = rvalid && (rid == 4'(i));
      w_bret[i]     = bvalid && r_bready && (bid == 4'(i));
      if (w_rret[i]) begin
        ch_rdata[32*i +: 32] = rdata;
      end
    end
  end

  assign ch_data_ok = w_rret | w_bret;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ptr      <= '0;
      r_rd_total <= '0;
      r_arvalid  <= 1'b0;
      r_arid     <= '0;
      r_araddr   <= '0;
      r_arsize   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_rd_cnt[i] <= '0;
      end
    end else begin
      if (w_gnt_vld) begin
        r_ptr <= w_nxt_ptr;
      end
      if (r_arvalid && arready) begin
        r_arvalid <= 1'b0;
      end
      if (w_rd_gnt) begin
        r_arvalid <= 1'b1;
        r_arid    <= 4'(w_gnt);
        r_araddr  <= w_sel_addr;
        r_arsize  <= {1'b0, w_sel_size};
      end
      // grant and return in one cycle net to no change
      for (int i = 0; i < NUM_CH; i++) begin
        r_rd_cnt[i] <= r_rd_cnt[i]
          + 4'(w_rd_gnt && (w_gnt == PW'(i)))
          - 4'(w_rret[i]);
      end
      r_rd_total <= r_rd_total + 4'(w_rd_gnt) - 4'(|w_rret);
    end
  end

  assign w_aw_done = !r_awvalid || awready;
  assign w_w_done  = !r_wvalid || wready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wst     <= S_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_wch     <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awsize  <= '0;
    end else begin
      unique case (r_wst)
        S_IDLE: begin
          if (w_wr_gnt) begin
            r_wst     <= S_SEND;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_wch     <= 4'(w_gnt);
            r_waddr   <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_wstrb   <= w_sel_wstrb;
            r_awsize  <= {1'b0, w_sel_size};
          end
        end
        S_SEND: begin
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_wst    <= S_WAITB;
            r_bready <= 1'b1;
          end
        end
        S_WAITB: begin
          if (bvalid) begin
            r_wst    <= S_IDLE;
            r_bready <= 1'b0;
          end
        end
        default: r_wst <= S_IDLE;
      endcase
    end
  end

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = 8'd0;
  assign arsize  = r_arsize;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = r_arvalid;
  assign rready  = 1'b1;

  assign awid    = r_wch;
  assign awaddr  = r_waddr;
  assign awlen   = 8'd0;
  assign awsize  = r_awsize;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = r_awvalid;

  assign wid     = r_wch;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

endmodule

// File: tb/tb_sram_axi_bridge_mc.sv
// Testbench for sram_axi_bridge_mc (NUM_CH=2, MAX_RD=4).
// Transaction-level scoreboard plus directed scenarios.
module tb_sram_axi_bridge_mc;
  localparam int NC = 2;
  localparam int MR = 4;
`ifdef SRAM_AXI_BRIDGE_RAW_CHECK_EN
  localparam logic [1:0] RAW_EXP = 2'b01;
  localparam int RAW_N = 2;
`else
  localparam logic [1:0] RAW_EXP = 2'b00;
  localparam int RAW_N = 1;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [NC-1:0]    ch_req, ch_wr, ch_addr_ok, ch_data_ok;
  logic [2*NC-1:0]  ch_size;
  logic [4*NC-1:0]  ch_wstrb;
  logic [32*NC-1:0] ch_addr, ch_wdata, ch_rdata;
  logic [3:0]  arid, rid, awid, wid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sram_axi_bridge_mc #(.NUM_CH(NC), .MAX_RD(MR)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
    .ch_rdata(ch_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } a_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
  } w_t;

  a_t arq[$];
  a_t awq[$];
  w_t wq[$];
  int m_rd_ch [NC];
  bit m_wr_out;
  logic [31:0] m_wr_addr;
  logic [NC-1:0] m_dok;
  bit m_blk;

  // model: expectations from the bus-level rules, checked every cycle
  always @(negedge aclk) begin
    if (!aresetn) begin
      arq.delete(); awq.delete(); wq.delete();
      for (int i = 0; i < NC; i++) m_rd_ch[i] = 0;
      m_wr_out = 0;
    end else begin
      chk("const_outs",
        {arlen, awlen, arburst, awburst, arlock, awlock, arcache,
         awcache, arprot, awprot, wlast, rready},
        {8'd0, 8'd0, 2'b01, 2'b01, 2'b00, 2'b00, 4'd0, 4'd0,
         3'd0, 3'd0, 1'b1, 1'b1});
      chk("addr_ok_onehot", 64'($onehot0(ch_addr_ok)), 64'd1);
      m_dok = '0;
      if (rvalid) m_dok[rid[0]] = 1'b1;
      if (bvalid) m_dok[bid[0]] = 1'b1;
      chk("data_ok", ch_data_ok, m_dok);
      if (rvalid) chk("rdata_route", ch_rdata[32*rid +: 32], rdata);
      if (arvalid && arready) begin
        if (arq.size() == 0) chk("ar_unexpected", 1, 0);
        else chk("ar_txn", {arid, araddr, arsize}, arq.pop_front());
      end
      if (awvalid && awready) begin
        if (awq.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("aw_txn", {awid, awaddr, awsize}, awq.pop_front());
      end
      if (wvalid && wready) begin
        if (wq.size() == 0) chk("w_unexpected", 1, 0);
        else chk("w_txn", {wid, wdata, wstrb}, wq.pop_front());
      end
      for (int i = 0; i < NC; i++) begin
        if (ch_addr_ok[i] && !ch_wr[i]) begin
`ifdef SRAM_AXI_BRIDGE_RAW_CHECK_EN
          m_blk = m_wr_out &&
            (ch_addr[32*i+2 +: 30] == m_wr_addr[31:2]);
`else
          m_blk = m_wr_out;
`endif
          chk("raw_rule", m_blk, 0);
          arq.push_back({4'(i), ch_addr[32*i +: 32],
                         {1'b0, ch_size[2*i +: 2]}});
          m_rd_ch[i]++;
        end else if (ch_addr_ok[i]) begin
          chk("wr_single", m_wr_out, 0);
          chk("wr_after_rd", m_rd_ch[i], 0);
          m_wr_out = 1;
          m_wr_addr = ch_addr[32*i +: 32];
          awq.push_back({4'(i), ch_addr[32*i +: 32],
                         {1'b0, ch_size[2*i +: 2]}});
          wq.push_back({4'(i), ch_wdata[32*i +: 32],
                        ch_wstrb[4*i +: 4]});
        end
      end
      if (rvalid) m_rd_ch[rid[0]]--;
      chk("rd_limit", 64'((m_rd_ch[0] + m_rd_ch[1]) <= MR), 64'd1);
      if (bvalid) m_wr_out = 0;
    end
  end

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  logic [1:0] seq [4];
  logic [1:0] acc;
  int n;

  initial begin
    ch_req = '0; ch_wr = '0; ch_size = 4'b1010; ch_wstrb = '1;
    ch_addr = '0; ch_wdata = '0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1;
    rvalid = 0; awready = 0; wready = 0; bid = 0; bresp = 0;
    bvalid = 0;
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    nxt();
    @(negedge aclk);
    chk("reset_state",
      {arvalid, awvalid, wvalid, bready, ch_addr_ok, ch_data_ok}, 0);
    nxt();
    aresetn = 1;

    // round-robin between two reading channels
    arready = 1;
    ch_req = 2'b11;
    ch_addr = {32'h2000, 32'h1000};
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      chk("rr_addr_ok", ch_addr_ok, seq[k]);
      if (k > 0) chk("rr_arid", arid, 64'((k - 1) % 2));
      nxt();
    end
    ch_req = 0;
    nxt();
    for (int k = 0; k < 4; k++) begin
      rvalid = 1; rid = 4'(k % 2); rdata = 32'hA000_0000 + k;
      @(negedge aclk);
      chk("rr_ret", ch_data_ok, (k % 2) ? 2'b10 : 2'b01);
      nxt();
    end
    rvalid = 0;

    // MAX_RD limit
    ch_req = 2'b01;
    ch_addr = {32'h0, 32'h3000};
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      if (ch_addr_ok[0]) n++;
      nxt();
    end
    chk("maxrd_count", n, 4);
    rvalid = 1; rid = 0; rdata = 32'h3000_0001;
    @(negedge aclk);
    chk("maxrd_blk_rvalid", ch_addr_ok, 0);
    nxt();
    rvalid = 0;
    @(negedge aclk);
    chk("maxrd_fifth", ch_addr_ok, 2'b01);
    nxt();
    @(negedge aclk);
    chk("maxrd_blk_again", ch_addr_ok, 0);
    nxt();
    ch_req = 0;
    for (int k = 0; k < 4; k++) begin
      rvalid = 1; rid = 0; rdata = 32'h3100_0000 + k;
      nxt();
    end
    rvalid = 0;

    // out-of-order return across IDs
    ch_req = 2'b11;
    ch_addr = {32'hB0, 32'hA0};
    acc = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      acc = acc | ch_addr_ok;
      nxt();
    end
    chk("ooo_both_granted", acc, 2'b11);
    ch_req = 0;
    nxt();
    rvalid = 1; rid = 1; rdata = 32'h1111_1111;
    @(negedge aclk);
    chk("ooo_ok1", ch_data_ok, 2'b10);
    chk("ooo_data1", ch_rdata[63:32], 32'h1111_1111);
    nxt();
    rid = 0; rdata = 32'h2222_2222;
    @(negedge aclk);
    chk("ooo_ok0", ch_data_ok, 2'b01);
    chk("ooo_data0", ch_rdata[31:0], 32'h2222_2222);
    nxt();
    rvalid = 0;

    // write with awready three cycles ahead of wready
    ch_req = 2'b10; ch_wr = 2'b10;
    ch_addr = {32'h1c00_0010, 32'h0};
    ch_wdata = {32'hdead_beef, 32'h0};
    ch_wstrb = {4'b0011, 4'b1111};
    @(negedge aclk);
    chk("wr_addr_ok", ch_addr_ok, 2'b10);
    nxt();
    ch_req = 0; ch_wr = 0;
    awready = 1;
    @(negedge aclk);
    chk("wr_send", {awvalid, wvalid, awid, wid, awaddr},
        {2'b11, 4'd1, 4'd1, 32'h1c00_0010});
    nxt();
    awready = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      chk("wr_aw_first", {awvalid, wvalid}, 2'b01);
      nxt();
    end
    wready = 1;
    @(negedge aclk);
    chk("wr_w_held", {awvalid, wvalid, wdata, wstrb},
        {2'b01, 32'hdead_beef, 4'b0011});
    nxt();
    wready = 0;
    @(negedge aclk);
    chk("wr_waitb", {awvalid, wvalid, bready, ch_data_ok}, 5'b00100);
    nxt();
    bvalid = 1; bid = 1;
    @(negedge aclk);
    chk("wr_done", ch_data_ok, 2'b10);
    nxt();
    bvalid = 0;
    @(negedge aclk);
    chk("wr_done_once", {ch_data_ok, bready}, 0);
    nxt();

    // read-after-write hazard
    ch_req = 2'b10; ch_wr = 2'b10;
    ch_addr = {32'h100, 32'h0};
    @(negedge aclk);
    chk("raw_wr_grant", ch_addr_ok, 2'b10);
    nxt();
    ch_req = 2'b01; ch_wr = 0;
    ch_addr = {32'h0, 32'h104};
    @(negedge aclk);
    chk("raw_diff_word", ch_addr_ok, RAW_EXP);
    nxt();
    ch_addr = {32'h0, 32'h102};
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      chk("raw_same_word", ch_addr_ok, 0);
      nxt();
    end
    awready = 1; wready = 1;
    @(negedge aclk);
    chk("raw_send_blk", ch_addr_ok, 0);
    nxt();
    awready = 0; wready = 0;
    @(negedge aclk);
    chk("raw_waitb_blk", ch_addr_ok, 0);
    nxt();
    bvalid = 1; bid = 1;
    @(negedge aclk);
    chk("raw_bvalid_blk", ch_addr_ok, 0);
    nxt();
    bvalid = 0;
    @(negedge aclk);
    chk("raw_release", ch_addr_ok, 2'b01);
    nxt();
    ch_req = 0;
    for (int k = 0; k < RAW_N; k++) begin
      rvalid = 1; rid = 0; rdata = 32'h5150_0000 + k;
      nxt();
    end
    rvalid = 0;

    // reset while AR held and write in WAIT_B
    arready = 0;
    ch_req = 2'b01; ch_wr = 0;
    ch_addr = {32'h600, 32'h500};
    @(negedge aclk);
    chk("rst_rd_grant", ch_addr_ok, 2'b01);
    nxt();
    ch_req = 2'b10; ch_wr = 2'b10;
    awready = 1; wready = 1;
    @(negedge aclk);
    chk("rst_wr_grant", ch_addr_ok, 2'b10);
    nxt();
    ch_req = 0; ch_wr = 0;
    nxt();
    @(negedge aclk);
    chk("rst_pre", {arvalid, bready}, 2'b11);
    nxt();
    aresetn = 0;
    nxt();
    aresetn = 1;
    arready = 1;
    ch_req = 2'b01; ch_wr = 2'b01;
    ch_addr = {32'h0, 32'h700};
    @(negedge aclk);
    chk("rst_mid_valids", {arvalid, awvalid, wvalid, bready}, 0);
    chk("rst_cnt_clear", ch_addr_ok, 2'b01);
    nxt();
    ch_req = 0; ch_wr = 0;
    nxt();
    awready = 0; wready = 0;
    bvalid = 1; bid = 0;
    @(negedge aclk);
    chk("rst_wr_done", ch_data_ok, 2'b01);
    nxt();
    bvalid = 0;
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge_mc.md
Name: sram_axi_bridge_mc

Overview:
Parametrised successor to the two-port SRAM-like-to-AXI bridge. Serves NUM_CH SRAM-like master channels (inst, data, future cache/uncached ports) on one AXI3 master interface. Uses round-robin arbitration, up to MAX_RD outstanding reads, and one outstanding write. Channel index is carried as the AXI ID, and responses are routed back by rid/bid. Sits between cpu_core and the SoC AXI crossbar inside mycpu_top.

Parameters:
NUM_CH, 2, number of SRAM-like channels (2..8); channel i gets AXI ID i.
MAX_RD, 4, maximum total outstanding read transactions (1..15).

Ports:
aclk  in  1  clock.
aresetn  in  1  reset.
ch_req  in  NUM_CH  request, per channel.
ch_wr  in  NUM_CH  1 = write, 0 = read.
ch_size  in  2*NUM_CH  0/1/2 = byte/half/word.
ch_wstrb  in  4*NUM_CH  write strobes.
ch_addr  in  32*NUM_CH  byte address.
ch_wdata  in  32*NUM_CH  write data.
ch_addr_ok  out  NUM_CH  request accepted this cycle.
ch_data_ok  out  NUM_CH  read data valid / write complete.
ch_rdata  out  32*NUM_CH  read data; valid with ch_data_ok.
arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI read address.
arready  in  1  AXI read address ready.
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data.
rready  out  1  AXI read data ready.
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1  AXI write address.
awready  in  1  AXI write address ready.
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data.
wready  in  1  AXI write data ready.
bid/bresp/bvalid  in  4/2/1  AXI write response.
bready  out  1  AXI write response ready.

Behaviour:
- Clock and reset: single clock aclk; reset aresetn, synchronous, active-low.
- Reset values: all valids, addr_ok and data_ok are 0. Counters clear, write FSM goes to IDLE, RR pointer = 0. Reset mid-transaction drops all tracking.
- Constant outputs: arlen = awlen = 0, arburst = awburst = 2'b01, lock/cache/prot = 0, wlast = 1, rready = 1.
- Arbitration: at most one addr_ok bit per cycle. Channels are scanned round-robin starting at ptr. The first eligible requesting channel is granted, and ptr becomes granted+1 (mod NUM_CH).
- Read eligibility: AR register empty (arvalid = 0, or arready this cycle), rd_total < MAX_RD, channel has no outstanding write, and the read is not RAW-blocked.
- Write eligibility: write FSM IDLE and channel has rd_cnt[ch] = 0.
- Read grant: latch araddr, arsize = {0, size} and arid = ch. Set arvalid, held until arready. rd_cnt[ch]++ and rd_total++.
- Read return: on rvalid, ch_data_ok[rid] = 1 and ch_rdata[rid] = rdata that same cycle (combinational). rd_cnt[rid]-- and rd_total--.
- Simultaneous read grant and read return: counters net unchanged.
- Write FSM: IDLE -> SEND on grant. SEND asserts awvalid and wvalid together; each drops independently on its own handshake. SEND -> WAIT_B when both handshakes are done, including both in the same cycle. WAIT_B asserts bready. On bvalid: ch_data_ok[bid] = 1, then IDLE.
- Write data: awid = wid = ch, awsize from size, wdata/wstrb latched at grant.
- Simultaneous completions: rvalid and bvalid in the same cycle go to different channels by construction, and both data_ok bits assert.
- Ordering: read data per channel returns in request order (same ID).
- rresp/bresp are ignored.

Optional Feature:
Macro SRAM_AXI_BRIDGE_RAW_CHECK_EN.
- Defined: a read is RAW-blocked only if a write is outstanding (FSM not IDLE) and addr[31:2] equals the latched write address[31:2].
- Undefined: every read is blocked whenever the write FSM is not IDLE (conservative).

Test Plan:
- NUM_CH=2, both channels issue a read every cycle, arready = 1 -> addr_ok alternates ch0, ch1, ch0; arid alternates 0, 1, 0.
- MAX_RD=4, rvalid held 0, ch0 issues 6 reads -> exactly 4 addr_ok pulses; the 5th is accepted only the cycle after the first rvalid (rid = 0).
- Reads to ch0 and ch1 returned out of order (rid 1 then rid 0, rdata 0x11111111 then 0x22222222) -> ch_data_ok[1] with 0x11111111, then ch_data_ok[0] with 0x22222222.
- ch1 writes 0x1c000010, wstrb = 4'b0011; awready 3 cycles before wready -> awvalid drops first, wvalid is held; single ch_data_ok[1] pulse on bvalid.
- RAW: write outstanding to 0x100, then ch0 reads 0x104 -> accepted only if the macro is defined. A read of 0x102 is blocked until bvalid in both builds.
- aresetn low for one cycle with arvalid = 1 and the write FSM in WAIT_B -> next cycle all valids = 0, FSM IDLE, counters 0.
